video_src_switch: RTL and testbench
===================================

VIDEO_SRC_SWITCH -- requirements
Module: video_src_switch

Interface
REQ-001 Parameter NUM_SRC, default 4, number of video sources (2..8).
REQ-002 Parameter DEFAULT_SRC, default 0, source selected after reset.
REQ-003 Parameter SRC_FMT, default 0, packed 2 bits per source: 0 RGB888, 1 RAW8, 2 RGB565.
REQ-004 Parameter H_PIXELS, default 1920, expected pixels per line.
REQ-005 Parameter V_PIXELS, default 1080, expected lines per frame.
REQ-006 One clock; reset is synchronous and active-high: pixel_clock in 1 (all sources synchronous to it), reset in 1.
REQ-007 src_vs in NUM_SRC, per-source frame sync, active-high.
REQ-008 src_de in NUM_SRC, per-source pixel valid.
REQ-009 src_data in NUM_SRC*24, per-source pixel, source k at [24k+23:24k], RAW8/RGB565 LSB-aligned.
REQ-010 sel_req in 1, one-cycle pulse requesting a source change.
REQ-011 sel_in in 3, requested source index.
REQ-012 wr_load out 1, one-cycle frame-start pulse to frame buffer writer.
REQ-013 wrfifo_wren out 1, pixel write enable.
REQ-014 wrfifo_din out 32, {R,G,B,8'hFF}.
REQ-015 active_src out 3, currently streamed source.
REQ-016 switch_busy out 1, high while a switch is pending or awaiting the new source's frame start.
REQ-017 sel_err out 1, one-cycle pulse on an illegal request.

Function
REQ-018 States: IDLE, STREAM, WAIT_VS; reset enters IDLE with active_src=DEFAULT_SRC.
REQ-019 vs edge = src_vs[active_src] high in the current registered sample and low in the previous one.
REQ-020 IDLE -> STREAM on a vs edge of active_src, issuing wr_load.
REQ-021 In STREAM, each active-source pixel with src_de high produces wrfifo_wren=1 exactly 2 cycles later; wr_load is also 2 cycles after its vs edge.
REQ-022 Packing: RGB888 pass-through; RAW8 {d,d,d}; RGB565 {r5,3'b0,g6,2'b0,b5,3'b0}.
REQ-023 sel_req with sel_in>=NUM_SRC: ignored, sel_err pulses 1 cycle later.
REQ-024 sel_req with sel_in==active_src while not switch_busy: ignored, no sel_err.
REQ-025 Legal sel_req in STREAM latches pending target; streaming continues to end of current frame.
REQ-026 In STREAM with pending target, next vs edge of active_src: no wr_load; active_src<=target; -> WAIT_VS.
REQ-027 WAIT_VS: wrfifo_wren held 0; vs edge of new active_src -> STREAM with wr_load; switch_busy clears in that cycle.
REQ-028 sel_req coinciding with the frame-ending vs edge takes effect at that edge.
REQ-029 A new legal sel_req while pending or in WAIT_VS retargets to the newest index; in WAIT_VS, active_src updates immediately.
REQ-030 Non-selected sources never influence outputs.

Reset
REQ-031 Reset values: wr_load=0, wrfifo_wren=0, wrfifo_din=0, sel_err=0, switch_busy=0, active_src=DEFAULT_SRC, pipeline and pending target cleared.
REQ-032 Reset asserted mid-frame aborts the frame; first output after release requires a fresh vs edge.

Configuration
REQ-033 Macro VIDEO_SRC_STATS_EN defined: add outputs frame_cnt[15:0] (increments on each wr_load, wraps 0xFFFF->0), line_len[11:0] (wren count of last completed line), geom_err (1-cycle pulse when a line length != H_PIXELS or lines per frame != V_PIXELS, checked at de fall and frame end respectively).
REQ-034 Macro undefined: those ports and counters are absent; all other behaviour identical.

Verification
REQ-035 Reset, source 0 RGB888 frame, 4x2 test geometry -> wr_load once, 8 wren, data 0x123456 -> din 0x123456FF, 2-cycle latency.
REQ-036 Source 1 RAW8 pixel 0xA5 -> din 0xA5A5A5FF; RGB565 0xFFFF -> din 0xF8FCF8FF.
REQ-037 sel_req to 2 mid-frame -> frame on 0 completes; no wr_load at its next vs; wren 0 until source 2 vs edge; then wr_load, active_src=2.
REQ-038 sel_in=5 with NUM_SRC=4 -> sel_err pulse, active_src unchanged; sel_in=active_src -> no effect.
REQ-039 Reset for one cycle mid-line -> all outputs 0 next cycle; no wren until next vs edge.
REQ-040 With VIDEO_SRC_STATS_EN, 3-pixel line in 4-pixel geometry -> geom_err pulse, line_len=3; frame_cnt wraps from 0xFFFF to 0.

Source files
------------

// File: rtl/video_src_switch.sv
`default_nettype none
// ============================================================================
// Module      : video_src_switch
// Description : Selects one of NUM_SRC pixel-synchronous video sources and
//               streams its frames into a frame-buffer write FIFO as
//               {R,G,B,8'hFF} words. Source changes are frame-aligned: the
//               current frame finishes, then output stays quiet until the
//               new source presents a frame start.
// Ports       : pixel_clock, reset (sync, active-high)
//               src_vs/src_de/src_data : per-source sync, valid, 24b pixel
//               sel_req/sel_in         : source-change request pulse + index
//               wr_load                : frame-start pulse to the writer
//               wrfifo_wren/wrfifo_din : pixel write strobe and packed word
//               active_src, switch_busy, sel_err : selection status
//               frame_cnt, line_len, geom_err    : stats (optional)
// Options     : define VIDEO_SRC_STATS_EN to build the statistics outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module video_src_switch #(
  parameter int          NUM_SRC     = 4,
  parameter int          DEFAULT_SRC = 0,
  parameter logic [15:0] SRC_FMT     = 16'h0000,
  parameter int          H_PIXELS    = 1920,
  parameter int          V_PIXELS    = 1080
) (
  input  logic                    pixel_clock,
  input  logic                    reset,
  input  logic [NUM_SRC-1:0]      src_vs,
  input  logic [NUM_SRC-1:0]      src_de,
  input  logic [NUM_SRC*24-1:0]   src_data,
  input  logic                    sel_req,
  input  logic [2:0]              sel_in,
  output logic                    wr_load,
  output logic                    wrfifo_wren,
  output logic [31:0]             wrfifo_din,
  output logic [2:0]              active_src,
  output logic                    switch_busy,
  output logic                    sel_err
`ifdef VIDEO_SRC_STATS_EN
  ,
  output logic [15:0]             frame_cnt,
  output logic [11:0]             line_len,
  output logic                    geom_err
`endif
);

  localparam logic [1:0] c_fmt_raw8   = 2'd1;
  localparam logic [1:0] c_fmt_rgb565 = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STREAM  = 2'd1,
    ST_WAIT_VS = 2'd2
  } state_t;

  if (NUM_SRC < 2 || NUM_SRC > 8 || DEFAULT_SRC < 0 || DEFAULT_SRC >= NUM_SRC ||
      H_PIXELS < 1 || H_PIXELS > 4095 || V_PIXELS < 1 || V_PIXELS > 4095) begin : g_param_chk
    $error("video_src_switch: parameter out of range");
  end

  // input sample stage (all sources) and previous vs sample for edge detect
  logic [NUM_SRC-1:0]    r_vs_s1, r_vs_s2, r_de_s1;
  logic [NUM_SRC*24-1:0] r_data_s1;

  state_t      r_state, w_state_nx;
  logic [2:0]  r_active, w_active_nx;
  logic        r_pending, w_pending_nx;
  logic [2:0]  r_target, w_target_nx;
  logic        r_load, w_load_nx;
  logic        r_wren, w_wren_nx;
  logic [31:0] r_din, w_din_nx;
  logic        r_err;

  logic        w_vs_cur, w_vs_prev, w_vs_edge, w_de_cur;
  logic [23:0] w_pix;
  logic [1:0]  w_fmt;
  logic [31:0] w_packed;
  logic        w_req_legal, w_req_bad;
  logic [2:0]  w_tgt_eff;
  logic        w_pend_eff;

  // only the active source's lanes reach the datapath
  always_comb begin
    w_vs_cur  = 1'b0;
    w_vs_prev = 1'b0;
    w_de_cur  = 1'b0;
    w_pix     = '0;
    w_fmt     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (r_active == 3'(k)) begin
        w_vs_cur  = r_vs_s1[k];
        w_vs_prev = r_vs_s2[k];
        w_de_cur  = r_de_s1[k];
        w_pix     = r_data_s1[24*k +: 24];
        w_fmt     = SRC_FMT[2*k +: 2];
      end
    end
  end

  assign w_vs_edge = w_vs_cur & ~w_vs_prev;

  always_comb begin
    case (w_fmt)
      c_fmt_raw8:   w_packed = {w_pix[7:0], w_pix[7:0], w_pix[7:0], 8'hFF};
      c_fmt_rgb565: w_packed = {w_pix[15:11], 3'b000, w_pix[10:5], 2'b00,
                                w_pix[4:0], 3'b000, 8'hFF};
      default:      w_packed = {w_pix, 8'hFF};
    endcase
  end

  assign w_req_legal = sel_req & ({1'b0, sel_in} < 4'(NUM_SRC));
  assign w_req_bad   = sel_req & ~w_req_legal;

  // A legal request in the same cycle as the frame-ending edge must count,
  // so the switch decision uses the request merged with the latched target.
  // Re-requesting the current source cancels any pending switch.
  assign w_tgt_eff  = w_req_legal ? sel_in : r_target;
  assign w_pend_eff = w_req_legal ? (sel_in != r_active) : r_pending;

  always_comb begin
    w_state_nx   = r_state;
    w_active_nx  = r_active;
    w_pending_nx = r_pending;
    w_target_nx  = r_target;
    w_load_nx    = 1'b0;
    w_wren_nx    = 1'b0;
    w_din_nx     = r_din;
    case (r_state)
      ST_STREAM: begin
        if (w_vs_edge && w_pend_eff) begin
          // frame boundary with a switch queued: no frame start here
          w_active_nx  = w_tgt_eff;
          w_pending_nx = 1'b0;
          w_state_nx   = ST_WAIT_VS;
        end else begin
          if (w_vs_edge) begin
            w_load_nx    = 1'b1;
            w_pending_nx = 1'b0;
          end else begin
            w_pending_nx = w_pend_eff;
            w_target_nx  = w_tgt_eff;
          end
          if (w_de_cur) begin
            w_wren_nx = 1'b1;
            w_din_nx  = w_packed;
          end
        end
      end
      default: begin
        // IDLE and WAIT_VS: nothing streams, so a new index applies at once
        if (w_req_legal && (sel_in != r_active)) begin
          w_active_nx = sel_in;
        end else if (w_vs_edge) begin
          w_state_nx = ST_STREAM;
          w_load_nx  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      // seed the vs history with the live level so a sync already high
      // across reset is not mistaken for a fresh frame start
      r_vs_s1   <= src_vs;
      r_vs_s2   <= src_vs;
      r_de_s1   <= '0;
      r_data_s1 <= '0;
      r_state   <= ST_IDLE;
      r_active  <= 3'(DEFAULT_SRC);
      r_pending <= 1'b0;
      r_target  <= '0;
      r_load    <= 1'b0;
      r_wren    <= 1'b0;
      r_din     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_vs_s1   <= src_vs;
      r_vs_s2   <= r_vs_s1;
      r_de_s1   <= src_de;
      r_data_s1 <= src_data;
      r_state   <= w_state_nx;
      r_active  <= w_active_nx;
      r_pending <= w_pending_nx;
      r_target  <= w_target_nx;
      r_load    <= w_load_nx;
      r_wren    <= w_wren_nx;
      r_din     <= w_din_nx;
      r_err     <= w_req_bad;
    end
  end

  assign wr_load     = r_load;
  assign wrfifo_wren = r_wren;
  assign wrfifo_din  = r_din;
  assign active_src  = r_active;
  assign switch_busy = r_pending | (r_state == ST_WAIT_VS);
  assign sel_err     = r_err;

`ifdef VIDEO_SRC_STATS_EN
  logic [NUM_SRC-1:0] r_de_s2;
  logic               w_de_prev;
  logic [15:0]        r_frame_cnt;
  logic [11:0]        r_line_len, r_pix_cnt, r_line_cnt;
  logic               r_geom_err;

  always_comb begin
    w_de_prev = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (r_active == 3'(k)) w_de_prev = r_de_s2[k];
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      r_de_s2     <= '0;
      r_frame_cnt <= '0;
      r_line_len  <= '0;
      r_pix_cnt   <= '0;
      r_line_cnt  <= '0;
      r_geom_err  <= 1'b0;
    end else begin
      r_de_s2    <= r_de_s1;
      r_geom_err <= 1'b0;
      if (w_load_nx) r_frame_cnt <= r_frame_cnt + 16'd1;
      if ((r_state == ST_STREAM) && w_vs_edge) begin
        // end of the frame just streamed
        if (r_line_cnt != 12'(V_PIXELS)) r_geom_err <= 1'b1;
        r_line_cnt <= '0;
        r_pix_cnt  <= '0;
      end else if (w_vs_edge && (w_state_nx == ST_STREAM)) begin
        r_line_cnt <= '0;
        r_pix_cnt  <= '0;
      end else if (r_state == ST_STREAM) begin
        if (w_wren_nx) r_pix_cnt <= r_pix_cnt + 12'd1;
        if (!w_de_cur && w_de_prev) begin
          r_line_len <= r_pix_cnt;
          r_pix_cnt  <= '0;
          r_line_cnt <= r_line_cnt + 12'd1;
          if (r_pix_cnt != 12'(H_PIXELS)) r_geom_err <= 1'b1;
        end
      end
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign line_len  = r_line_len;
  assign geom_err  = r_geom_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_video_src_switch.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_src_switch
// Description : Directed self-checking bench for video_src_switch with four
//               sources (0 RGB888, 1 RAW8, 2 RGB565, 3 RGB888) and a 4x2
//               frame geometry. Inputs change 1 ns after the rising edge,
//               outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_src_switch;

  logic        pixel_clock = 1'b0;
  logic        reset;
  logic [3:0]  src_vs, src_de;
  logic [95:0] src_data;
  logic        sel_req;
  logic [2:0]  sel_in;
  logic        wr_load, wrfifo_wren, switch_busy, sel_err;
  logic [31:0] wrfifo_din;
  logic [2:0]  active_src;
`ifdef VIDEO_SRC_STATS_EN
  logic [15:0] frame_cnt;
  logic [11:0] line_len;
  logic        geom_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 pixel_clock = ~pixel_clock;

  video_src_switch #(
    .NUM_SRC(4), .DEFAULT_SRC(0), .SRC_FMT(16'h0024), .H_PIXELS(4), .V_PIXELS(2)
  ) dut (
    .pixel_clock(pixel_clock), .reset(reset),
    .src_vs(src_vs), .src_de(src_de), .src_data(src_data),
    .sel_req(sel_req), .sel_in(sel_in),
    .wr_load(wr_load), .wrfifo_wren(wrfifo_wren), .wrfifo_din(wrfifo_din),
    .active_src(active_src), .switch_busy(switch_busy), .sel_err(sel_err)
`ifdef VIDEO_SRC_STATS_EN
    , .frame_cnt(frame_cnt), .line_len(line_len), .geom_err(geom_err)
`endif
  );

  // one clock cycle: drive just after the rising edge, return at the falling edge
  task automatic step(input logic [3:0] vs, input logic [3:0] de, input logic [95:0] data,
                      input logic req, input logic [2:0] sel);
    @(posedge pixel_clock);
    #1;
    src_vs = vs; src_de = de; src_data = data; sel_req = req; sel_in = sel;
    @(negedge pixel_clock);
  endtask

  // 14-cycle 4x2 frame on src: vs at c0, lines at c2..c5 and c7..c10.
  // The next source up toggles vs every cycle with de high as interference.
  // Outputs at cycle c reflect stimulus of cycle c-2.
  task automatic stream_frame(input int src, input logic [23:0] pix, input logic [31:0] exp_din,
                              input bit exp_load, input bit exp_stream,
                              input int req_at, input logic [2:0] req_sel);
    logic [3:0]  vs, de;
    logic [95:0] data;
    bit          de_at [0:13];
    bit          exp_l, exp_w;
    int          nb;
    nb = (src + 1) % 4;
    for (int c = 0; c < 14; c++) de_at[c] = ((c >= 2 && c <= 5) || (c >= 7 && c <= 10));
    for (int c = 0; c < 14; c++) begin
      vs = '0; de = '0; data = '0;
      vs[src] = (c == 0);
      de[src] = de_at[c];
      data[24*src +: 24] = pix;
      vs[nb] = c[0];
      de[nb] = 1'b1;
      data[24*nb +: 24] = 24'h0F0F0F;
      step(vs, de, data, (c == req_at), req_sel);
      exp_l = exp_load && (c == 2);
      exp_w = (c >= 2) ? (exp_stream && de_at[c-2]) : 1'b0;
      n_cmp++;
      if (wr_load !== exp_l) begin
        n_bad++;
        $display("FAIL frame_src%0d_c%0d wr_load got %b want %b", src, c, wr_load, exp_l);
      end
      n_cmp++;
      if (wrfifo_wren !== exp_w) begin
        n_bad++;
        $display("FAIL frame_src%0d_c%0d wren got %b want %b", src, c, wrfifo_wren, exp_w);
      end
      if (exp_w) begin
        n_cmp++;
        if (wrfifo_din !== exp_din) begin
          n_bad++;
          $display("FAIL frame_src%0d_c%0d din got %h want %h", src, c, wrfifo_din, exp_din);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(4'h0, 4'h0, 96'h0, 1'b0, 3'd0);
    step(4'h0, 4'h0, 96'h0, 1'b0, 3'd0);
    n_cmp++;
    if ({wr_load, wrfifo_wren, sel_err, switch_busy} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 0000", {wr_load, wrfifo_wren, sel_err, switch_busy});
    end
    n_cmp++;
    if (wrfifo_din !== 32'h0) begin
      n_bad++; $display("FAIL reset_din got %h want 00000000", wrfifo_din);
    end
    n_cmp++;
    if (active_src !== 3'd0) begin
      n_bad++; $display("FAIL reset_active got %0d want 0", active_src);
    end
`ifdef VIDEO_SRC_STATS_EN
    n_cmp++;
    if ({frame_cnt, line_len, geom_err} !== 29'h0) begin
      n_bad++; $display("FAIL reset_stats got %h want 0", {frame_cnt, line_len, geom_err});
    end
`endif
    reset = 1'b0;
    // pixels without a frame start must not stream
    for (int i = 0; i < 5; i++) begin
      step(4'h0, 4'h1, 96'h123456, 1'b0, 3'd0);
      n_cmp++;
      if ({wr_load, wrfifo_wren} !== 2'b00) begin
        n_bad++; $display("FAIL idle_no_vs_%0d got %b want 00", i, {wr_load, wrfifo_wren});
      end
    end
  endtask

  task automatic test_rgb888_frame();
    stream_frame(0, 24'h123456, 32'h123456FF, 1'b1, 1'b1, -1, 3'd0);
    n_cmp++;
    if ({active_src, switch_busy} !== {3'd0, 1'b0}) begin
      n_bad++; $display("FAIL rgb888_status got %0d/%b want 0/0", active_src, switch_busy);
    end
  endtask

  task automatic test_switch_mid_frame();
    // request source 2 between the two lines of a source-0 frame
    stream_frame(0, 24'h123456, 32'h123456FF, 1'b1, 1'b1, 6, 3'd2);
    n_cmp++;
    if ({active_src, switch_busy} !== {3'd0, 1'b1}) begin
      n_bad++; $display("FAIL switch_pending got %0d/%b want 0/1", active_src, switch_busy);
    end
    // next source-0 frame start: no load, no pixels, source 2 becomes active
    stream_frame(0, 24'h123456, 32'h123456FF, 1'b0, 1'b0, -1, 3'd0);
    n_cmp++;
    if ({active_src, switch_busy} !== {3'd2, 1'b1}) begin
      n_bad++; $display("FAIL switch_wait got %0d/%b want 2/1", active_src, switch_busy);
    end
    stream_frame(2, 24'h00FFFF, 32'hF8FCF8FF, 1'b1, 1'b1, -1, 3'd0);
    n_cmp++;
    if ({active_src, switch_busy} !== {3'd2, 1'b0}) begin
      n_bad++; $display("FAIL switch_done got %0d/%b want 2/0", active_src, switch_busy);
    end
  endtask

  task automatic test_raw8_coincident();
    // request lands in the cycle the frame-ending edge is seen
    stream_frame(2, 24'h00FFFF, 32'hF8FCF8FF, 1'b0, 1'b0, 1, 3'd1);
    n_cmp++;
    if ({active_src, switch_busy} !== {3'd1, 1'b1}) begin
      n_bad++; $display("FAIL coincident_switch got %0d/%b want 1/1", active_src, switch_busy);
    end
    stream_frame(1, 24'h0000A5, 32'hA5A5A5FF, 1'b1, 1'b1, -1, 3'd0);
  endtask

  task automatic test_sel_err();
    step(4'h0, 4'h0, 96'h0, 1'b1, 3'd5);
    step(4'h0, 4'h0, 96'h0, 1'b0, 3'd0);
    n_cmp++;
    if ({sel_err, active_src, switch_busy} !== {1'b1, 3'd1, 1'b0}) begin
      n_bad++; $display("FAIL sel_err_pulse got %b/%0d/%b want 1/1/0", sel_err, active_src, switch_busy);
    end
    step(4'h0, 4'h0, 96'h0, 1'b0, 3'd0);
    n_cmp++;
    if (sel_err !== 1'b0) begin
      n_bad++; $display("FAIL sel_err_width got %b want 0", sel_err);
    end
    step(4'h0, 4'h0, 96'h0, 1'b1, 3'd1);
    step(4'h0, 4'h0, 96'h0, 1'b0, 3'd0);
    n_cmp++;
    if ({sel_err, active_src, switch_busy} !== {1'b0, 3'd1, 1'b0}) begin
      n_bad++; $display("FAIL sel_same got %b/%0d/%b want 0/1/0", sel_err, active_src, switch_busy);
    end
    step(4'h0, 4'h0, 96'h0, 1'b0, 3'd0);
    n_cmp++;
    if (switch_busy !== 1'b0) begin
      n_bad++; $display("FAIL sel_same_busy got %b want 0", switch_busy);
    end
  endtask

  task automatic test_wait_retarget();
    stream_frame(1, 24'h0000A5, 32'hA5A5A5FF, 1'b1, 1'b1, 3, 3'd0);
    n_cmp++;
    if ({active_src, switch_busy} !== {3'd1, 1'b1}) begin
      n_bad++; $display("FAIL retarget_pending got %0d/%b want 1/1", active_src, switch_busy);
    end
    // switch to 0 at the edge, then retarget to 3 while waiting
    stream_frame(1, 24'h0000A5, 32'hA5A5A5FF, 1'b0, 1'b0, 6, 3'd3);
    n_cmp++;
    if ({active_src, switch_busy} !== {3'd3, 1'b1}) begin
      n_bad++; $display("FAIL retarget_wait got %0d/%b want 3/1", active_src, switch_busy);
    end
    stream_frame(3, 24'h654321, 32'h654321FF, 1'b1, 1'b1, -1, 3'd0);
  endtask

  task automatic test_reset_midframe();
    logic [95:0] d;
    d = 96'h0;
    d[95:72] = 24'h654321;
    d[23:0]  = 24'h123456;
    step(4'h8, 4'h0, d, 1'b0, 3'd0);
    step(4'h0, 4'h0, d, 1'b0, 3'd0);
    step(4'h0, 4'h8, d, 1'b0, 3'd0);
    step(4'h0, 4'h8, d, 1'b0, 3'd0);
    reset = 1'b1;
    step(4'h0, 4'h9, d, 1'b0, 3'd0);
    n_cmp++;
    if ({wr_load, wrfifo_wren, sel_err, switch_busy, active_src, wrfifo_din} !== 39'h0) begin
      n_bad++;
      $display("FAIL midreset_outputs got %b%b%b%b/%0d/%h want all 0", wr_load, wrfifo_wren,
               sel_err, switch_busy, active_src, wrfifo_din);
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step((i == 3) ? 4'h8 : 4'h0, 4'h9, d, 1'b0, 3'd0);
      n_cmp++;
      if ({wr_load, wrfifo_wren} !== 2'b00) begin
        n_bad++; $display("FAIL midreset_quiet_%0d got %b want 00", i, {wr_load, wrfifo_wren});
      end
    end
    stream_frame(0, 24'h123456, 32'h123456FF, 1'b1, 1'b1, -1, 3'd0);
  endtask

`ifdef VIDEO_SRC_STATS_EN
  task automatic test_stats();
    n_cmp++;
    if ({frame_cnt, line_len, geom_err} !== {16'd1, 12'd4, 1'b0}) begin
      n_bad++; $display("FAIL stats_after_frame got %0d/%0d/%b want 1/4/0", frame_cnt, line_len, geom_err);
    end
    // frame with a 3-pixel line
    for (int c = 0; c < 9; c++) begin
      step((c == 0) ? 4'h1 : 4'h0, (c >= 2 && c <= 4) ? 4'h1 : 4'h0, 96'h0, 1'b0, 3'd0);
      if (c == 2) begin
        n_cmp++;
        if ({frame_cnt, geom_err} !== {16'd2, 1'b0}) begin
          n_bad++; $display("FAIL stats_frame_start got %0d/%b want 2/0", frame_cnt, geom_err);
        end
      end
      if (c == 7) begin
        n_cmp++;
        if ({geom_err, line_len} !== {1'b1, 12'd3}) begin
          n_bad++; $display("FAIL stats_short_line got %b/%0d want 1/3", geom_err, line_len);
        end
      end
      if (c == 8) begin
        n_cmp++;
        if (geom_err !== 1'b0) begin
          n_bad++; $display("FAIL stats_err_width got %b want 0", geom_err);
        end
      end
    end
    for (int n = 0; n < 65533; n++) begin
      step(4'h1, 4'h0, 96'h0, 1'b0, 3'd0);
      step(4'h0, 4'h0, 96'h0, 1'b0, 3'd0);
    end
    step(4'h0, 4'h0, 96'h0, 1'b0, 3'd0);
    step(4'h0, 4'h0, 96'h0, 1'b0, 3'd0);
    n_cmp++;
    if (frame_cnt !== 16'hFFFF) begin
      n_bad++; $display("FAIL stats_cnt_max got %h want ffff", frame_cnt);
    end
    step(4'h1, 4'h0, 96'h0, 1'b0, 3'd0);
    step(4'h0, 4'h0, 96'h0, 1'b0, 3'd0);
    step(4'h0, 4'h0, 96'h0, 1'b0, 3'd0);
    step(4'h0, 4'h0, 96'h0, 1'b0, 3'd0);
    n_cmp++;
    if (frame_cnt !== 16'h0000) begin
      n_bad++; $display("FAIL stats_cnt_wrap got %h want 0000", frame_cnt);
    end
  endtask
`endif

  initial begin
    reset    = 1'b1;
    src_vs   = '0;
    src_de   = '0;
    src_data = '0;
    sel_req  = 1'b0;
    sel_in   = '0;
    test_reset();
    test_rgb888_frame();
    test_switch_mid_frame();
    test_raw8_coincident();
    test_sel_err();
    test_wait_retarget();
    test_reset_midframe();
`ifdef VIDEO_SRC_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
